ir_cmd_framer: RTL and testbench

Converts decoded NEC IR remote frames into framed, checksummed command packets for the UART transmitter.
- Validates each IR code, filters it through a key mask and suppresses auto-repeats.
- Merges in the operating-mode bits and queues commands in a FIFO.
- Emits 3-byte packets (SYNC, PAYLOAD, CHECKSUM) over a valid/ready byte stream.
- Resends the last command as a keepalive while idle.
- Sits between IR_RECEIVE and uart_tx.

---
 rtl/ir_cmd_pkg.sv | 21 ++
 rtl/ir_cmd_framer_if.sv | 9 +
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/ir_cmd_framer.sv | 212 +++++++++++++++++++++
 tb/tb_ir_cmd_framer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_cmd_pkg.sv
// Shared types and constants for the IR command framer: FSM states, NEC field
// positions and the packet checksum rule.
package ir_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  localparam int KEY_LSB = 16;
  localparam int INV_LSB = 24;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] pkt_csum(input logic [7:0] sync, input logic [7:0] payload);
    return sync ^ payload;
  endfunction

endpackage

// File: rtl/ir_cmd_framer_if.sv
// Byte stream from the framer to the UART transmitter (valid/ready handshake).
interface ir_cmd_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with a registered occupancy count; a push into a full FIFO
// still lands when a pop happens in the same cycle.
module cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  // A pop on an empty FIFO is ignored, so a same-cycle push+pop there only pushes.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Entry storage; contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ir_cmd_framer.sv
// Turns decoded NEC IR frames into SYNC/PAYLOAD/CHECKSUM byte packets with key
// filtering, repeat suppression, a command FIFO and an idle keepalive resend.
module ir_cmd_framer
  import ir_cmd_pkg::*;
#(
  parameter  int                  CMD_W         = 4,
  parameter  logic [2**CMD_W-1:0] KEY_MASK      = 16'h03FF,
  parameter  int                  DEPTH         = 8,
  parameter  int                  HOLDOFF_CYC   = 12_500_000,
  parameter  int                  KEEPALIVE_CYC = 25_000_000,
  parameter  logic [7:0]          SYNC_BYTE     = SYNC_DEFAULT,
  localparam int                  MODE_W        = 8 - CMD_W,
  localparam int                  LVL_W         = $clog2(DEPTH + 1),
  localparam int                  HW            = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1,
  localparam int                  KW            = (KEEPALIVE_CYC > 0) ? $clog2(KEEPALIVE_CYC + 1) : 1
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iDATA_READY,
  input  logic [31:0]         iDATA,
  input  logic [MODE_W-1:0]   iMODE,
  ir_cmd_framer_if.master     tx,
  output logic [LVL_W-1:0]    oFIFO_LEVEL,
  output logic                oOVERFLOW,
  output logic [7:0]          oLAST_CMD
);

  logic [7:0]       key_s;
  logic [7:0]       inv_s;
  logic             frame_ok_s;
  logic             unused_s;
  logic             dec_valid_r;
  logic [CMD_W-1:0] dec_key_r;
  logic [CMD_W-1:0] last_key_r;
  logic [HW-1:0]    holdoff_r;
  logic             suppress_s;
  logic             accept_s;
  logic             overflow_r;
  logic             fifo_pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  state_e           state_r;
  state_e           state_n;
  logic [7:0]       payload_r;
  logic [7:0]       payload_n;
  logic [7:0]       tx_data_r;
  logic [7:0]       tx_data_n;
  logic             tx_valid_r;
  logic [7:0]       last_cmd_r;
  logic             have_last_r;
  logic             done_s;
  logic [KW-1:0]    idle_cnt_r;
  logic             ka_fire_s;

  assign key_s      = iDATA[KEY_LSB +: 8];
  assign inv_s      = iDATA[INV_LSB +: 8];
  assign frame_ok_s = (inv_s == ~key_s) && (int'(key_s) < (2 ** CMD_W))
                      && KEY_MASK[key_s[CMD_W-1:0]];
  assign unused_s   = ^iDATA[KEY_LSB-1:0];

  // Decode stage: the frame check result lands one cycle after the strobe.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      dec_valid_r <= 1'b0;
      dec_key_r   <= {CMD_W{1'b0}};
    end else begin
      dec_valid_r <= iDATA_READY && frame_ok_s;
      dec_key_r   <= key_s[CMD_W-1:0];
    end
  end

  // Holdoff restarts on every valid frame, so a held button never re-fires.
  assign suppress_s = dec_valid_r && (dec_key_r == last_key_r) && (holdoff_r != {HW{1'b0}});
  assign accept_s   = dec_valid_r && !suppress_s;

  // Repeat-suppression window and last accepted key.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      holdoff_r  <= {HW{1'b0}};
      last_key_r <= {CMD_W{1'b0}};
    end else begin
      if (dec_valid_r) begin
        holdoff_r <= HW'(HOLDOFF_CYC);
      end else if (holdoff_r != {HW{1'b0}}) begin
        holdoff_r <= holdoff_r - HW'(1);
      end
      if (accept_s) begin
        last_key_r <= dec_key_r;
      end
    end
  end

  cmd_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .push      (accept_s),
    .push_data ({iMODE, dec_key_r}),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (oFIFO_LEVEL)
  );

  // Sticky drop flag for pushes that found the FIFO full with no pop.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      overflow_r <= 1'b0;
    end else if (accept_s && fifo_full_s && !fifo_pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign ka_fire_s = (KEEPALIVE_CYC != 0) && have_last_r
                     && (idle_cnt_r == KW'(KEEPALIVE_CYC));

  // Packet FSM next-state, FIFO pop and completion strobe.
  always_comb begin
    state_n    = state_r;
    payload_n  = payload_r;
    fifo_pop_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          payload_n  = fifo_dout_s;
          state_n    = ST_SYNC;
        end else if (ka_fire_s) begin
          payload_n  = last_cmd_r;
          state_n    = ST_SYNC;
        end else begin
          state_n    = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (tx.tx_ready) state_n = ST_PAYLOAD;
        else             state_n = ST_SYNC;
      end
      ST_PAYLOAD: begin
        if (tx.tx_ready) state_n = ST_CSUM;
        else             state_n = ST_PAYLOAD;
      end
      ST_CSUM: begin
        if (tx.tx_ready) begin
          state_n = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_n = ST_CSUM;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output byte is computed from the next state so data/valid leave registers.
  always_comb begin
    tx_data_n = 8'h00;
    case (state_n)
      ST_SYNC:    tx_data_n = SYNC_BYTE;
      ST_PAYLOAD: tx_data_n = payload_n;
      ST_CSUM:    tx_data_n = pkt_csum(SYNC_BYTE, payload_n);
      default:    tx_data_n = 8'h00;
    endcase
  end

  // FSM state, payload and registered stream outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r     <= ST_IDLE;
      payload_r   <= 8'h00;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      last_cmd_r  <= 8'h00;
      have_last_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      payload_r  <= payload_n;
      tx_data_r  <= tx_data_n;
      tx_valid_r <= (state_n != ST_IDLE);
      if (done_s) begin
        last_cmd_r  <= payload_r;
        have_last_r <= 1'b1;
      end
    end
  end

  // Idle counter: runs only while idle with nothing queued, zero elsewhere.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      idle_cnt_r <= {KW{1'b0}};
    end else if ((state_r != ST_IDLE) || (state_n != ST_IDLE)) begin
      idle_cnt_r <= {KW{1'b0}};
    end else if (fifo_empty_s && (idle_cnt_r != KW'(KEEPALIVE_CYC))) begin
      idle_cnt_r <= idle_cnt_r + KW'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign oOVERFLOW   = overflow_r;
  assign oLAST_CMD   = last_cmd_r;

endmodule

// File: tb/tb_ir_cmd_framer.sv
// Scenario bench for ir_cmd_framer: expected payloads are queued as frames are
// driven and matched against packets captured from the byte stream.
module tb_ir_cmd_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        data_ready = 1'b0;
  logic [31:0] data = 32'h0;
  logic [3:0]  mode = 4'h0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  last_cmd;

  ir_cmd_framer_if bus ();

  ir_cmd_framer #(
    .CMD_W         (4),
    .KEY_MASK      (16'h03FF),
    .DEPTH         (8),
    .HOLDOFF_CYC   (100),
    .KEEPALIVE_CYC (200),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .iDATA_READY (data_ready),
    .iDATA       (data),
    .iMODE       (mode),
    .tx          (bus.master),
    .oFIFO_LEVEL (fifo_level),
    .oOVERFLOW   (overflow),
    .oLAST_CMD   (last_cmd)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         acc_q[$];
  int         rise_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture accepted bytes and rising edges of valid, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      rx_q.push_back(bus.tx_data);
      acc_q.push_back(cyc);
    end
    if (bus.tx_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid <= bus.tx_valid;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    data_ready = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); rx_q.delete(); acc_q.delete(); rise_q.delete();
  endtask

  // One-cycle frame strobe; returns #1 after the edge that sampled it.
  task automatic send_raw(input logic [15:0] hi, input logic [3:0] md, input bit expect_pkt);
    data = {hi, 16'h1234};
    mode = md;
    data_ready = 1'b1;
    if (expect_pkt) exp_q.push_back({md, hi[3:0]});
    @(posedge clk); #1;
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.tx_valid); else passed++;
    total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.tx_data); else passed++;
    total++; if (fifo_level !== 4'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL reset_last_cmd got %h want 00", last_cmd); else passed++;
  endtask

  task automatic test_single_key();
    logic [7:0] e, b0, b1, b2;
    bus.tx_ready = 1'b1;
    send_raw(16'hFA05, 4'h3, 1'b1);
    total++; if (bus.tx_valid !== 1'b0) $display("FAIL single_n1 valid got %0b want 0", bus.tx_valid); else passed++;
    @(posedge clk); #1;
    total++; if (bus.tx_valid !== 1'b0) $display("FAIL single_n2 valid got %0b want 0", bus.tx_valid); else passed++;
    @(posedge clk); #1;
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA5}) $display("FAIL single_n3 valid/data got %0b/%h want 1/a5", bus.tx_valid, bus.tx_data); else passed++;
    repeat (8) @(posedge clk); #1;
    total++; if (rx_q.size() !== 3 * exp_q.size()) $display("FAIL single_count got %0d bytes want %0d", rx_q.size(), 3 * exp_q.size()); else passed++;
    while (exp_q.size() > 0 && rx_q.size() >= 3) begin
      e = exp_q.pop_front(); b0 = rx_q.pop_front(); b1 = rx_q.pop_front(); b2 = rx_q.pop_front();
      total++; if ({b0, b1, b2} !== {8'hA5, e, 8'hA5 ^ e}) $display("FAIL single_pkt got %h %h %h want a5 %h %h", b0, b1, b2, e, 8'hA5 ^ e); else passed++;
    end
    total++; if (last_cmd !== 8'h35) $display("FAIL single_last_cmd got %h want 35", last_cmd); else passed++;
  endtask

  task automatic test_bad_frame();
    bit saw_valid = 1'b0;
    bit level_nz = 1'b0;
    apply_reset();
    bus.tx_ready = 1'b1;
    send_raw(16'hFB05, 4'h3, 1'b0);
    send_raw(16'hF30C, 4'h3, 1'b0);
    send_raw(16'hEF10, 4'h3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (bus.tx_valid) saw_valid = 1'b1;
      if (fifo_level != 4'd0) level_nz = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_valid) $display("FAIL bad_frame_valid got 1 want 0"); else passed++;
    total++; if (level_nz) $display("FAIL bad_frame_level got nonzero want 0"); else passed++;
  endtask

  task automatic test_repeat();
    logic [7:0] e, b0, b1, b2;
    apply_reset();
    bus.tx_ready = 1'b1;
    mode = 4'h3;
    for (int t = 0; t < 300; t++) begin
      if (t == 0 || t == 50 || t == 250) begin
        data = 32'hFA05_0000; data_ready = 1'b1;
        if (t != 50) exp_q.push_back(8'h35);
      end else if (t == 60) begin
        data = 32'hF906_0000; data_ready = 1'b1;
        exp_q.push_back(8'h36);
      end else begin
        data_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    data_ready = 1'b0;
    total++; if (rx_q.size() !== 3 * exp_q.size()) $display("FAIL repeat_count got %0d bytes want %0d", rx_q.size(), 3 * exp_q.size()); else passed++;
    while (exp_q.size() > 0 && rx_q.size() >= 3) begin
      e = exp_q.pop_front(); b0 = rx_q.pop_front(); b1 = rx_q.pop_front(); b2 = rx_q.pop_front();
      total++; if ({b0, b1, b2} !== {8'hA5, e, 8'hA5 ^ e}) $display("FAIL repeat_pkt got %h %h %h want a5 %h %h", b0, b1, b2, e, 8'hA5 ^ e); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e, b0, b1, b2;
    bit held_ok = 1'b1;
    apply_reset();
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      send_raw({~k[7:0], k[7:0]}, 4'hA, k < 9);
      repeat (3) begin
        @(posedge clk); #1;
        if (k > 0 && !(bus.tx_valid === 1'b1 && bus.tx_data === 8'hA5)) held_ok = 1'b0;
      end
    end
    total++; if (!held_ok) $display("FAIL bp_hold got valid/data %0b/%h want 1/a5", bus.tx_valid, bus.tx_data); else passed++;
    total++; if (fifo_level !== 4'd8) $display("FAIL bp_level got %0d want 8", fifo_level); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL bp_overflow got %0b want 1", overflow); else passed++;
    bus.tx_ready = 1'b1;
    repeat (60) @(posedge clk); #1;
    total++; if (fifo_level !== 4'd0) $display("FAIL bp_drained_level got %0d want 0", fifo_level); else passed++;
    total++; if (rx_q.size() !== 3 * exp_q.size()) $display("FAIL bp_count got %0d bytes want %0d", rx_q.size(), 3 * exp_q.size()); else passed++;
    while (exp_q.size() > 0 && rx_q.size() >= 3) begin
      e = exp_q.pop_front(); b0 = rx_q.pop_front(); b1 = rx_q.pop_front(); b2 = rx_q.pop_front();
      total++; if ({b0, b1, b2} !== {8'hA5, e, 8'hA5 ^ e}) $display("FAIL bp_pkt got %h %h %h want a5 %h %h", b0, b1, b2, e, 8'hA5 ^ e); else passed++;
    end
  endtask

  task automatic test_keepalive();
    logic [7:0] e, b0, b1, b2;
    apply_reset();
    bus.tx_ready = 1'b1;
    send_raw(16'hF807, 4'h1, 1'b1);
    exp_q.push_back(8'h17);
    exp_q.push_back(8'h17);
    repeat (430) @(posedge clk); #1;
    total++; if (rise_q.size() !== 3) $display("FAIL ka_rises got %0d want 3", rise_q.size()); else passed++;
    if (rise_q.size() >= 3 && acc_q.size() >= 3) begin
      total++; if (rise_q[1] - (acc_q[2] + 1) !== 201) $display("FAIL ka_first_gap got %0d want 201", rise_q[1] - (acc_q[2] + 1)); else passed++;
      total++; if (rise_q[2] - rise_q[1] !== 204) $display("FAIL ka_period got %0d want 204", rise_q[2] - rise_q[1]); else passed++;
    end else begin
      total++; $display("FAIL ka_timing got %0d rises want 3", rise_q.size());
    end
    total++; if (rx_q.size() !== 3 * exp_q.size()) $display("FAIL ka_count got %0d bytes want %0d", rx_q.size(), 3 * exp_q.size()); else passed++;
    while (exp_q.size() > 0 && rx_q.size() >= 3) begin
      e = exp_q.pop_front(); b0 = rx_q.pop_front(); b1 = rx_q.pop_front(); b2 = rx_q.pop_front();
      total++; if ({b0, b1, b2} !== {8'hA5, e, 8'hA5 ^ e}) $display("FAIL ka_pkt got %h %h %h want a5 %h %h", b0, b1, b2, e, 8'hA5 ^ e); else passed++;
    end
  endtask

  task automatic test_reset_mid_packet();
    int w = 0;
    apply_reset();
    bus.tx_ready = 1'b1;
    send_raw(16'hF609, 4'h2, 1'b0);
    repeat (8) @(posedge clk); #1;
    total++; if (last_cmd !== 8'h29) $display("FAIL mid_last_before got %h want 29", last_cmd); else passed++;
    bus.tx_ready = 1'b0;
    send_raw(16'hFC03, 4'h2, 1'b0);
    while (!bus.tx_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    total++; if (bus.tx_valid !== 1'b1) $display("FAIL mid_sync_timeout got valid %0b want 1", bus.tx_valid); else passed++;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    total++; if (bus.tx_data !== 8'h23) $display("FAIL mid_payload got %h want 23", bus.tx_data); else passed++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_async_valid got %0b want 0", bus.tx_valid); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL mid_async_last got %h want 00", last_cmd); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rise_q.delete(); rx_q.delete(); acc_q.delete();
    bus.tx_ready = 1'b1;
    repeat (400) @(posedge clk); #1;
    total++; if (rise_q.size() !== 0) $display("FAIL mid_no_keepalive got %0d rises want 0", rise_q.size()); else passed++;
    send_raw(16'hFD02, 4'h0, 1'b0);
    repeat (215) @(posedge clk); #1;
    total++; if (last_cmd !== 8'h02) $display("FAIL mid_new_last got %h want 02", last_cmd); else passed++;
    total++; if (rise_q.size() !== 2) $display("FAIL mid_keepalive_resumed got %0d rises want 2", rise_q.size()); else passed++;
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    #1;
    apply_reset();
    test_reset();
    test_single_key();
    test_bad_frame();
    test_repeat();
    test_backpressure();
    test_keepalive();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
